// File: rtl/fc_pkg.sv
// fc_pkg: shared types and helpers for the fully-connected layer engine.
// Holds the FSM state enum, accumulator/address width helpers and the
// saturation and ReLU functions used on the output path.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        ACT,
        OUT,
        DONE
    } fc_state_e;

    // Accumulator width: a full product per input plus growth for N_IN terms,
    // so a whole row can be summed without overflow.
    function automatic int fc_acc_w(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in);
    endfunction

    // Address width for n locations, never narrower than one bit.
    function automatic int fc_addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Clamp a wide signed value into the signed data_w range.
    function automatic logic signed [63:0] fc_sat(input logic signed [63:0] x,
                                                  input int data_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Rectifier: negative values become zero.
    function automatic logic signed [63:0] fc_relu(input logic signed [63:0] x);
        return (x < 64'sd0) ? 64'sd0 : x;
    endfunction

endpackage

// File: rtl/fc_layer_engine_if.sv
// fc_layer_engine_if: memory read ports (weights, activations, bias) and the
// result stream of the layer engine. master = engine side, slave = memories
// plus result consumer.
interface fc_layer_engine_if
    import fc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int N_IN   = 8,
    parameter int N_OUT  = 2,
    parameter int W_BASE = 0
);
    localparam int C   = N_IN / LANES;
    localparam int AW  = fc_addr_w(W_BASE + N_OUT * C);
    localparam int AAW = fc_addr_w(C);
    localparam int IW  = fc_addr_w(N_OUT);

    logic [AW-1:0]           o_w_addr;
    logic [LANES*DATA_W-1:0] i_w_data;
    logic [AAW-1:0]          o_a_addr;
    logic [LANES*DATA_W-1:0] i_a_data;
    logic [IW-1:0]           o_b_addr;
    logic [DATA_W-1:0]       i_b_data;
    logic                    o_valid;
    logic                    i_ready;
    logic [DATA_W-1:0]       o_data;
    logic [IW-1:0]           o_idx;

    modport master (
        output o_w_addr, o_a_addr, o_b_addr, o_valid, o_data, o_idx,
        input  i_w_data, i_a_data, i_b_data, i_ready
    );

    modport slave (
        input  o_w_addr, o_a_addr, o_b_addr, o_valid, o_data, o_idx,
        output i_w_data, i_a_data, i_b_data, i_ready
    );

endinterface

// File: rtl/fc_mac_lanes.sv
// fc_mac_lanes: combinational multiply-accumulate across LANES word pairs.
// Each lane forms a signed full-precision product; the products are summed
// into an ACC_W-wide signed result.
module fc_mac_lanes
    import fc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ACC_W  = 35
) (
    input  logic [LANES*DATA_W-1:0] w_lanes,
    input  logic [LANES*DATA_W-1:0] a_lanes,
    output logic signed [ACC_W-1:0] sum
);
    logic signed [2*DATA_W-1:0] prod [LANES];

    // Per-lane signed products, sign-extended before multiplying.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            prod[j] = (2*DATA_W)'($signed(w_lanes[j*DATA_W +: DATA_W]))
                    * (2*DATA_W)'($signed(a_lanes[j*DATA_W +: DATA_W]));
        end
    end

    // Sum of all lane products.
    always_comb begin
        sum = '0;
        for (int j = 0; j < LANES; j++) begin
            sum = sum + ACC_W'(prod[j]);
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: computes N_OUT neurons of a fully-connected layer, LANES
// inputs per cycle, then adds bias, rescales, saturates and hands each result
// out over a valid/ready stream.
// Build option: define FC_RELU_EN to force negative results to zero.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LANES  = 4,
    parameter int N_IN   = 8,
    parameter int N_OUT  = 2,
    parameter int W_BASE = 0
) (
    input  logic clk,
    input  logic iRst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    fc_layer_engine_if.master bus
);
    localparam int C     = N_IN / LANES;
    localparam int ACC_W = fc_acc_w(DATA_W, N_IN);
    localparam int AW    = fc_addr_w(W_BASE + N_OUT * C);
    localparam int AAW   = fc_addr_w(C);
    localparam int IW    = fc_addr_w(N_OUT);
    localparam int CW    = fc_addr_w(C + 1);

    generate
        if (N_IN % LANES != 0) begin : g_bad_lanes
            $fatal(1, "fc_layer_engine: N_IN must be a multiple of LANES");
        end
        if (N_OUT < 1) begin : g_bad_nout
            $fatal(1, "fc_layer_engine: N_OUT must be at least 1");
        end
    endgenerate

    fc_state_e state_q, state_d;
    logic                     row_start;
    logic                     last_row;
    logic [IW-1:0]            row_q, row_next;
    logic [CW-1:0]            cnt_q;
    logic                     vld_p0, vld_p1;
    logic signed [ACC_W-1:0]  mac_p1, acc_p1;
    logic [AW-1:0]            w_addr_q;
    logic [AAW-1:0]           a_addr_q;
    logic [IW-1:0]            b_addr_q;
    logic signed [DATA_W-1:0] data_q;
    logic signed [63:0]       pre_w, shf_w, sat_w, res_w;

    fc_mac_lanes #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_mac (
        .w_lanes (bus.i_w_data),
        .a_lanes (bus.i_a_data),
        .sum     (mac_p1)
    );

    assign last_row = (row_q == IW'(N_OUT - 1));
    // A chunk address is issued while the counter is below C.
    assign vld_p0   = (state_q == ACCUM) && (cnt_q < CW'(C));

    // State register.
    always_ff @(posedge clk) begin
        if (iRst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state, plus row-start decode shared with the datapath.
    always_comb begin
        state_d   = state_q;
        row_start = 1'b0;
        row_next  = row_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d   = ACCUM;
                row_start = 1'b1;
                row_next  = '0;
            end
            ACCUM: if (cnt_q == CW'(C)) state_d = ACT;
            ACT:   state_d = OUT;
            OUT: if (bus.i_ready) begin
                if (last_row) begin
                    state_d = DONE;
                end else begin
                    state_d   = ACCUM;
                    row_start = 1'b1;
                    row_next  = row_q + IW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bias alignment, floor rescale and saturation of the finished sum.
    always_comb begin
        pre_w = 64'(acc_p1) + (64'($signed(bus.i_b_data)) <<< FRAC_W);
        shf_w = pre_w >>> FRAC_W;
        sat_w = fc_sat(shf_w, DATA_W);
`ifdef FC_RELU_EN
        res_w = fc_relu(sat_w);
`else
        res_w = sat_w;
`endif
    end

    // Row counter, chunk addressing, accumulation and result capture.
    always_ff @(posedge clk) begin
        if (iRst) begin
            row_q    <= '0;
            cnt_q    <= '0;
            vld_p1   <= 1'b0;
            acc_p1   <= '0;
            w_addr_q <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            data_q   <= '0;
        end else begin
            // Memory returns data one cycle after its address.
            vld_p1 <= vld_p0;
            if (row_start) begin
                row_q    <= row_next;
                cnt_q    <= '0;
                acc_p1   <= '0;
                w_addr_q <= AW'(W_BASE + int'(row_next) * C);
                a_addr_q <= '0;
                b_addr_q <= row_next;
            end else if (state_q == ACCUM) begin
                cnt_q <= cnt_q + CW'(1);
                if (vld_p1) acc_p1 <= acc_p1 + mac_p1;
                // Last chunk address stays put until the next row.
                if (cnt_q < CW'(C - 1)) begin
                    w_addr_q <= w_addr_q + AW'(1);
                    a_addr_q <= a_addr_q + AAW'(1);
                end
            end
            if (state_q == ACT) data_q <= DATA_W'(res_w);
        end
    end

    assign o_busy       = (state_q == ACCUM) || (state_q == ACT) || (state_q == OUT);
    assign o_done       = (state_q == DONE);
    assign bus.o_valid  = (state_q == OUT);
    assign bus.o_data   = data_q;
    assign bus.o_idx    = row_q;
    assign bus.o_w_addr = w_addr_q;
    assign bus.o_a_addr = a_addr_q;
    assign bus.o_b_addr = b_addr_q;

endmodule

// File: doc/fc_layer_engine.md
FC_LAYER_ENGINE -- requirements
Module: fc_layer_engine

Interface
REQ-001 Parameter: DATA_W, 16, signed fixed-point word width for activations, weights, biases and outputs.
REQ-002 Parameter: FRAC_W, 8, fractional bits of every DATA_W word.
REQ-003 Parameter: LANES, 4, parallel multiply lanes, i.e. words per memory read.
REQ-004 Parameter: N_IN, 8, inputs per neuron; N_IN % LANES == 0 is a fatal elaboration check.
REQ-005 Parameter: N_OUT, 2, output neurons; must be at least 1.
REQ-006 Parameter: W_BASE, 0, weight memory base address.
REQ-007 Port: clk, in, 1, single clock; all state changes on rising edge.
REQ-008 Port: iRst, in, 1, reset, synchronous and active-high.
REQ-009 Port: i_start, in, 1, one-cycle start request.
REQ-010 Port: o_busy, out, 1, high from accepted start until o_done.
REQ-011 Port: o_w_addr, out, AW, weight word address; AW = clog2(W_BASE + N_OUT*N_IN/LANES).
REQ-012 Port: i_w_data, in, LANES*DATA_W, weight lanes; lane j occupies bits [j*DATA_W +: DATA_W]; returned 1 cycle after address.
REQ-013 Port: o_a_addr, out, clog2(N_IN/LANES), activation chunk address.
REQ-014 Port: i_a_data, in, LANES*DATA_W, activation lanes; returned 1 cycle after address.
REQ-015 Port: o_b_addr, out, clog2(N_OUT), bias address.
REQ-016 Port: i_b_data, in, DATA_W, bias; returned 1 cycle after address.
REQ-017 Port: o_valid, out, 1, o_data holds a finished neuron.
REQ-018 Port: i_ready, in, 1, consumer accepts o_data.
REQ-019 Port: o_data, out, DATA_W, neuron result.
REQ-020 Port: o_idx, out, clog2(N_OUT), neuron index of o_data.
REQ-021 Port: o_done, out, 1, one-cycle pulse after the last neuron is accepted.

Function
REQ-022 FSM states SHALL be IDLE, ACCUM, ACT, OUT, DONE.
REQ-023 IDLE: i_start goes to ACCUM with row=0; i_start is ignored in every other state.
REQ-024 ACCUM: with C = N_IN/LANES, address chunk k = 0..C-1 is issued on cycle k, with o_w_addr = W_BASE + row*C + k, o_a_addr = k and o_b_addr = row.
REQ-025 ACCUM: lane data for chunk k SHALL be multiplied and summed, then added to the accumulator on cycle k+1; the accumulator clears at row start.
REQ-026 Accumulator width SHALL be ACC_W = 2*DATA_W + clog2(N_IN), signed, with no overflow possible.
REQ-027 ACT (cycle C+1): result = (acc + (bias <<< FRAC_W)) >>> FRAC_W, using arithmetic shift (floor), then saturated to the signed DATA_W range and registered into o_data.
REQ-028 OUT: o_valid is high and o_data/o_idx are held stable while i_ready is low.
REQ-029 OUT, on o_valid & i_ready: if row < N_OUT-1, row increments and the FSM enters ACCUM the next cycle; otherwise the FSM enters DONE.
REQ-030 Row latency, row start to o_valid, SHALL be C+2 cycles.
REQ-031 DONE: o_done pulses for 1 cycle, then the FSM returns to IDLE; o_busy falls in the same cycle o_done rises.
REQ-032 Addresses outside ACCUM SHALL hold their last value.

Reset
REQ-033 iRst high SHALL force IDLE, row=0, acc=0, o_valid=0, o_done=0, o_busy=0, o_data=0, o_idx=0 and all addresses 0, at any cycle including mid-row; a partial result is discarded and no o_done is issued.

Configuration
REQ-034 With FC_RELU_EN defined, a saturated negative result SHALL output 0; without it, the signed saturated value SHALL pass through unchanged.

Structure
REQ-035 Package fc_pkg SHALL hold the FSM state enum, the ACC_W function and the saturate/ReLU functions.
REQ-036 Sub-module fc_mac_lanes SHALL be combinational: LANES signed products and an adder tree, output ACC_W wide.

Verification (DATA_W=16, FRAC_W=8, LANES=4, N_IN=8, N_OUT=2)
REQ-037 Weights 0x0100, activations 0x0100, bias 0x0080, i_ready=1 -> o_data=0x0880 for idx 0 and 1; o_valid 4 cycles after row start; o_done once.
REQ-038 Weights 0xFF00, activations 0x0100, bias 0x0080 -> o_data=0x0000 with FC_RELU_EN, 0xF880 without.
REQ-039 Weights 0x7FFF, activations 0x7FFF -> o_data=0x7FFF (saturated); weights 0x8000 without FC_RELU_EN -> 0x8000.
REQ-040 i_ready held low for 5 cycles at idx 0 -> o_data/o_idx stable throughout; idx 1 begins the cycle after acceptance.
REQ-041 iRst asserted at cycle 2 of row 1 -> next cycle all outputs are 0 and no o_done; a new i_start then completes normally.
REQ-042 i_start pulsed while busy -> ignored; exactly N_OUT outputs and one o_done.
